// File: rtl/pkg_cmd_issuer_pkg.sv
// Shared constants and state encoding for the four-rank package command issuer.
package pkg_cmd_issuer_pkg;

  localparam int RANK_MSB  = 33;
  localparam int RANK_LSB  = 32;
  localparam int RANK_W    = RANK_MSB - RANK_LSB + 1;
  localparam int CMD_W     = 32;
  localparam int PKG_CMD_W = 34;

  typedef enum logic [1:0] {
    IDLE,
    SWITCH,
    ISSUE,
    WAIT_RD
  } state_t;

endpackage

// File: rtl/pkg_cmd_issuer_if.sv
// Request, package-side and response signals of the command issuer.
// The master view belongs to the issuer; the slave view belongs to the host/package side.
interface pkg_cmd_issuer_if #(
  parameter int DATA_W = 128
);
  import pkg_cmd_issuer_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [RANK_W-1:0]    req_rank;
  logic [CMD_W-1:0]     req_cmd;
  logic                 req_is_read;
  logic [DATA_W-1:0]    req_wdata;
  logic [PKG_CMD_W-1:0] pkg_command;
  logic                 pkg_valid;
  logic [DATA_W-1:0]    pkg_write_data;
  logic [DATA_W-1:0]    pkg_read_data;
  logic                 pkg_read_data_valid;
  logic [3:0]           pkg_ba_cmd_pm;
  logic                 rsp_valid;
  logic [DATA_W-1:0]    rsp_data;
  logic [RANK_W-1:0]    rsp_rank;
  logic [3:0]           status_pm;
  logic                 err_timeout;

  modport master (
    input  req_valid, req_rank, req_cmd, req_is_read, req_wdata,
    input  pkg_read_data, pkg_read_data_valid, pkg_ba_cmd_pm,
    output req_ready, pkg_command, pkg_valid, pkg_write_data,
    output rsp_valid, rsp_data, rsp_rank, status_pm, err_timeout
  );

  modport slave (
    output req_valid, req_rank, req_cmd, req_is_read, req_wdata,
    output pkg_read_data, pkg_read_data_valid, pkg_ba_cmd_pm,
    input  req_ready, pkg_command, pkg_valid, pkg_write_data,
    input  rsp_valid, rsp_data, rsp_rank, status_pm, err_timeout
  );

endinterface

// File: rtl/pkg_cmd_issuer_rd_timer.sv
// Loadable up/down counter that stops once it reaches its limit.
// Used for both the rank-switch settle gap and the read timeout.
module pkg_rd_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadVal,
  input  logic             i_en,
  input  logic             i_down,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_count;

  assign o_expire = (r_count == i_limit);

  // Counting freezes at the limit, so the count never wraps.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_en && !o_expire) begin
      r_count <= i_down ? (r_count - 1'b1) : (r_count + 1'b1);
    end
  end

endmodule

// File: rtl/pkg_cmd_issuer.sv
// Host-side initiator for the four-rank package: issues one command at a time,
// holds the rank stable across reads and inserts a settle gap on every rank change.
module pkg_cmd_issuer
  import pkg_cmd_issuer_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int SWITCH_GAP = 2,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                i_power_on_rst_n,
  pkg_cmd_issuer_if.master    bus
);

  localparam int TO_W = $clog2(RD_TIMEOUT);

  state_t              r_state;
  logic [RANK_W-1:0]   r_curRank;
  logic [CMD_W-1:0]    r_holdCmd;
  logic [DATA_W-1:0]   r_holdWdata;
  logic                r_holdIsRead;
  logic                r_reqReady;
  logic                r_pkgValid;
  logic [CMD_W-1:0]    r_pkgCmd;
  logic [DATA_W-1:0]   r_pkgWdata;
  logic                r_rspValid;
  logic [DATA_W-1:0]   r_rspData;
  logic [RANK_W-1:0]   r_rspRank;
  logic [3:0]          r_statusPm;
  logic                r_errTimeout;

  logic w_accept;
  logic w_gapLoad;
  logic w_gapExpire;
  logic w_toLoad;
  logic w_toExpire;

  assign w_accept  = (r_state == IDLE) && bus.req_valid && r_reqReady;
  assign w_gapLoad = w_accept && (bus.req_rank != r_curRank);
  assign w_toLoad  = (r_state == ISSUE) && r_holdIsRead;

  pkg_rd_timer #(.WIDTH(4)) u_gapTimer (
    .clk       (clk),
    .i_rst_n   (i_power_on_rst_n),
    .i_load    (w_gapLoad),
    .i_loadVal (4'(SWITCH_GAP)),
    .i_en      (r_state == SWITCH),
    .i_down    (1'b1),
    .i_limit   (4'd1),
    .o_expire  (w_gapExpire)
  );

  pkg_rd_timer #(.WIDTH(TO_W)) u_toTimer (
    .clk       (clk),
    .i_rst_n   (i_power_on_rst_n),
    .i_load    (w_toLoad),
    .i_loadVal ({TO_W{1'b0}}),
    .i_en      (r_state == WAIT_RD),
    .i_down    (1'b0),
    .i_limit   (TO_W'(RD_TIMEOUT - 1)),
    .o_expire  (w_toExpire)
  );

  // Command strobe, data and response are one-cycle pulses; everything else is held.
  always_ff @(posedge clk) begin
    if (!i_power_on_rst_n) begin
      r_state      <= IDLE;
      r_curRank    <= '0;
      r_holdCmd    <= '0;
      r_holdWdata  <= '0;
      r_holdIsRead <= 1'b0;
      r_reqReady   <= 1'b0;
      r_pkgValid   <= 1'b0;
      r_pkgCmd     <= '0;
      r_pkgWdata   <= '0;
      r_rspValid   <= 1'b0;
      r_rspData    <= '0;
      r_rspRank    <= '0;
      r_statusPm   <= '0;
      r_errTimeout <= 1'b0;
    end else begin
      r_pkgValid <= 1'b0;
      r_pkgCmd   <= '0;
      r_pkgWdata <= '0;
      r_rspValid <= 1'b0;
      if (r_state != SWITCH) begin
        r_statusPm <= bus.pkg_ba_cmd_pm;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_holdCmd    <= bus.req_cmd;
            r_holdWdata  <= bus.req_is_read ? '0 : bus.req_wdata;
            r_holdIsRead <= bus.req_is_read;
            r_reqReady   <= 1'b0;
            if (bus.req_rank == r_curRank) begin
              r_state    <= ISSUE;
              r_pkgValid <= 1'b1;
              r_pkgCmd   <= bus.req_cmd;
              r_pkgWdata <= bus.req_is_read ? '0 : bus.req_wdata;
            end else begin
              r_state   <= SWITCH;
              r_curRank <= bus.req_rank;
            end
          end else begin
            r_reqReady <= 1'b1;
          end
        end
        SWITCH: begin
          if (w_gapExpire) begin
            r_state    <= ISSUE;
            r_pkgValid <= 1'b1;
            r_pkgCmd   <= r_holdCmd;
            r_pkgWdata <= r_holdWdata;
          end
        end
        ISSUE: begin
          if (r_holdIsRead) begin
            r_state <= WAIT_RD;
          end else begin
            r_state    <= IDLE;
            r_reqReady <= 1'b1;
          end
        end
        WAIT_RD: begin
          // A strobe on the threshold cycle still counts as a good read.
          if (bus.pkg_read_data_valid) begin
            r_rspValid <= 1'b1;
            r_rspData  <= bus.pkg_read_data;
            r_rspRank  <= r_curRank;
            r_state    <= IDLE;
            r_reqReady <= 1'b1;
          end else if (w_toExpire) begin
            r_errTimeout <= 1'b1;
            r_state      <= IDLE;
            r_reqReady   <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready                   = r_reqReady;
  assign bus.pkg_command[RANK_MSB:RANK_LSB] = r_curRank;
  assign bus.pkg_command[CMD_W-1:0]      = r_pkgCmd;
  assign bus.pkg_valid                   = r_pkgValid;
  assign bus.pkg_write_data              = r_pkgWdata;
  assign bus.rsp_valid                   = r_rspValid;
  assign bus.rsp_data                    = r_rspData;
  assign bus.rsp_rank                    = r_rspRank;
  assign bus.status_pm                   = r_statusPm;
  assign bus.err_timeout                 = r_errTimeout;

endmodule

// File: tb/tb_pkg_cmd_issuer.sv
// Directed, table-driven bench for pkg_cmd_issuer with hand-written sequences
// for the read timeout, exact-threshold data strobe and mid-read reset.
module tb_pkg_cmd_issuer;

  localparam int DATA_W     = 128;
  localparam int SWITCH_GAP = 2;
  localparam int RD_TIMEOUT = 64;
  localparam int NUM_VEC    = 17;

  typedef struct {
    logic         v;
    logic [1:0]   rank;
    logic [31:0]  cmd;
    logic         rd;
    logic [127:0] wd;
    logic         dv;
    logic [127:0] rdat;
    logic         eReady;
    logic         ePv;
    logic [1:0]   eRank;
    logic [31:0]  eCmdLo;
    logic [127:0] eWd;
    logic         eRsp;
    logic [127:0] eRspData;
    logic [1:0]   eRspRank;
    logic [3:0]   ePm;
    logic         eErr;
  } vec_t;

  logic clk = 1'b0;
  logic rstN;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[NUM_VEC];

  logic [127:0] patA5;
  logic [127:0] patDead;
  logic [127:0] patBeef;
  logic [127:0] patCafe;

  always #5 clk = ~clk;

  pkg_cmd_issuer_if #(.DATA_W(DATA_W)) bus ();

  pkg_cmd_issuer #(
    .DATA_W     (DATA_W),
    .SWITCH_GAP (SWITCH_GAP),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) dut (
    .clk              (clk),
    .i_power_on_rst_n (rstN),
    .bus              (bus)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] rank, input logic [31:0] cmd,
                               input logic rd, input logic [127:0] wd,
                               input logic dv, input logic [127:0] rdat);
    bus.req_valid           = v;
    bus.req_rank            = rank;
    bus.req_cmd             = cmd;
    bus.req_is_read         = rd;
    bus.req_wdata           = wd;
    bus.pkg_read_data_valid = dv;
    bus.pkg_read_data       = rdat;
  endtask

  function automatic vec_t idleRow(input logic [1:0] curRank, input logic [3:0] ePm);
    vec_t r;
    r.v = 1'b0; r.rank = '0; r.cmd = '0; r.rd = 1'b0; r.wd = '0; r.dv = 1'b0; r.rdat = '0;
    r.eReady = 1'b1; r.ePv = 1'b0; r.eRank = curRank; r.eCmdLo = '0; r.eWd = '0;
    r.eRsp = 1'b0; r.eRspData = '0; r.eRspRank = '0; r.ePm = ePm; r.eErr = 1'b0;
    return r;
  endfunction

  function automatic vec_t withReq(input vec_t r, input logic [1:0] rank, input logic [31:0] cmd,
                                   input logic rd, input logic [127:0] wd);
    vec_t o = r;
    o.v = 1'b1; o.rank = rank; o.cmd = cmd; o.rd = rd; o.wd = wd;
    return o;
  endfunction

  function automatic vec_t withIssue(input vec_t r, input logic [31:0] cmd, input logic [127:0] wd);
    vec_t o = r;
    o.eReady = 1'b0; o.ePv = 1'b1; o.eCmdLo = cmd; o.eWd = wd;
    return o;
  endfunction

  task automatic checkRow(input int idx, input vec_t r);
    string p;
    p = $sformatf("row%0d", idx);
    checkOutput({p, " req_ready"}, bus.req_ready, r.eReady);
    checkOutput({p, " pkg_valid"}, bus.pkg_valid, r.ePv);
    checkOutput({p, " pkg_command"}, bus.pkg_command, {r.eRank, r.eCmdLo});
    checkOutput({p, " pkg_write_data"}, bus.pkg_write_data, r.eWd);
    checkOutput({p, " rsp_valid"}, bus.rsp_valid, r.eRsp);
    checkOutput({p, " status_pm"}, bus.status_pm, r.ePm);
    checkOutput({p, " err_timeout"}, bus.err_timeout, r.eErr);
    if (r.eRsp) begin
      checkOutput({p, " rsp_data"}, bus.rsp_data, r.eRspData);
      checkOutput({p, " rsp_rank"}, bus.rsp_rank, r.eRspRank);
    end
  endtask

  task automatic waitRead(input int n, input string tag, input logic strobeLast, input logic [127:0] rdat);
    for (int k = 0; k < n; k++) begin
      tick();
      checkOutput($sformatf("%s wait%0d req_ready", tag, k), bus.req_ready, 1'b0);
      checkOutput($sformatf("%s wait%0d rsp_valid", tag, k), bus.rsp_valid, 1'b0);
      checkOutput($sformatf("%s wait%0d err_timeout", tag, k), bus.err_timeout, 1'b0);
      if (strobeLast && (k == n - 1)) applyStimulus(0, 0, 0, 0, '0, 1, rdat);
      else                            applyStimulus(0, 0, 0, 0, '0, 0, '0);
    end
  endtask

  initial begin
    patA5   = {16{8'hA5}};
    patDead = {4{32'hDEADBEEF}};
    patBeef = {8{16'hBEEF}};
    patCafe = {8{16'hCAFE}};

    // Row i is one clock cycle: expected outputs seen in that cycle, inputs driven during it.
    vecs[0]  = withReq(idleRow(2'd0, 4'd0), 2'd0, 32'h0000_1234, 1'b0, patA5);
    vecs[1]  = withIssue(idleRow(2'd0, 4'd1), 32'h0000_1234, patA5);
    vecs[2]  = withReq(idleRow(2'd0, 4'd2), 2'd2, 32'h0000_ABCD, 1'b1, 128'h0);
    vecs[3]  = idleRow(2'd2, 4'd3);  vecs[3].eReady = 1'b0;
    vecs[4]  = idleRow(2'd2, 4'd3);  vecs[4].eReady = 1'b0;
    vecs[5]  = withIssue(idleRow(2'd2, 4'd3), 32'h0000_ABCD, 128'h0);
    vecs[6]  = withReq(idleRow(2'd2, 4'd6), 2'd2, 32'h0000_0055, 1'b0, 128'h11);
    vecs[6].eReady = 1'b0;
    vecs[7]  = vecs[6];  vecs[7].ePm = 4'd7;
    vecs[8]  = vecs[6];  vecs[8].ePm = 4'd8;  vecs[8].dv = 1'b1;  vecs[8].rdat = patDead;
    vecs[9]  = withReq(idleRow(2'd2, 4'd9), 2'd2, 32'h0000_0055, 1'b0, 128'h11);
    vecs[9].eRsp = 1'b1;  vecs[9].eRspData = patDead;  vecs[9].eRspRank = 2'd2;
    vecs[10] = withIssue(idleRow(2'd2, 4'd10), 32'h0000_0055, 128'h11);
    vecs[10].dv = 1'b1;  vecs[10].rdat = patBeef;
    vecs[11] = idleRow(2'd2, 4'd11);  vecs[11].dv = 1'b1;  vecs[11].rdat = patBeef;
    vecs[12] = withReq(idleRow(2'd2, 4'd12), 2'd2, 32'h0000_0066, 1'b0, 128'h22);
    vecs[13] = withReq(withIssue(idleRow(2'd2, 4'd13), 32'h0000_0066, 128'h22),
                       2'd2, 32'h0000_0077, 1'b0, 128'h33);
    vecs[14] = withReq(idleRow(2'd2, 4'd14), 2'd2, 32'h0000_0077, 1'b0, 128'h33);
    vecs[15] = withIssue(idleRow(2'd2, 4'd15), 32'h0000_0077, 128'h33);
    vecs[16] = idleRow(2'd2, 4'd0);

    rstN = 1'b0;
    bus.pkg_ba_cmd_pm = 4'd0;
    applyStimulus(0, 0, 0, 0, '0, 0, '0);
    repeat (3) tick();
    checkOutput("reset req_ready", bus.req_ready, 1'b0);
    checkOutput("reset pkg_command", bus.pkg_command, 34'h0);
    checkOutput("reset pkg_valid", bus.pkg_valid, 1'b0);
    checkOutput("reset rsp_valid", bus.rsp_valid, 1'b0);
    checkOutput("reset status_pm", bus.status_pm, 4'd0);
    checkOutput("reset err_timeout", bus.err_timeout, 1'b0);
    rstN = 1'b1;

    for (int i = 0; i < NUM_VEC; i++) begin
      tick();
      checkRow(i, vecs[i]);
      applyStimulus(vecs[i].v, vecs[i].rank, vecs[i].cmd, vecs[i].rd, vecs[i].wd,
                    vecs[i].dv, vecs[i].rdat);
      bus.pkg_ba_cmd_pm = 4'(i + 1);
    end

    // Data strobe lands on the 64th wait cycle, the same cycle the timeout would fire.
    tick();
    checkOutput("exact ready", bus.req_ready, 1'b1);
    applyStimulus(1, 2'd2, 32'h0000_0088, 1, '0, 0, '0);
    tick();
    checkOutput("exact pkg_valid", bus.pkg_valid, 1'b1);
    checkOutput("exact pkg_command", bus.pkg_command, {2'd2, 32'h0000_0088});
    checkOutput("exact pkg_write_data", bus.pkg_write_data, 128'h0);
    applyStimulus(0, 0, 0, 0, '0, 0, '0);
    waitRead(RD_TIMEOUT, "exact", 1'b1, patCafe);
    tick();
    checkOutput("exact rsp_valid", bus.rsp_valid, 1'b1);
    checkOutput("exact rsp_data", bus.rsp_data, patCafe);
    checkOutput("exact rsp_rank", bus.rsp_rank, 2'd2);
    checkOutput("exact err_timeout", bus.err_timeout, 1'b0);
    checkOutput("exact ready after", bus.req_ready, 1'b1);
    applyStimulus(1, 2'd2, 32'h0000_0099, 1, '0, 0, '0);

    // Read that never returns data must time out without a response.
    tick();
    checkOutput("to pkg_valid", bus.pkg_valid, 1'b1);
    checkOutput("to pkg_command", bus.pkg_command, {2'd2, 32'h0000_0099});
    checkOutput("to rsp_valid after exact", bus.rsp_valid, 1'b0);
    applyStimulus(0, 0, 0, 0, '0, 0, '0);
    waitRead(RD_TIMEOUT, "to", 1'b0, '0);
    tick();
    checkOutput("to err_timeout", bus.err_timeout, 1'b1);
    checkOutput("to req_ready", bus.req_ready, 1'b1);
    checkOutput("to rsp_valid", bus.rsp_valid, 1'b0);
    applyStimulus(1, 2'd2, 32'h0000_00AA, 0, 128'h44, 0, '0);
    tick();
    checkOutput("sticky pkg_command", bus.pkg_command, {2'd2, 32'h0000_00AA});
    checkOutput("sticky pkg_write_data", bus.pkg_write_data, 128'h44);
    checkOutput("sticky err1", bus.err_timeout, 1'b1);
    applyStimulus(0, 0, 0, 0, '0, 0, '0);
    tick();
    checkOutput("sticky err2", bus.err_timeout, 1'b1);
    checkOutput("sticky ready", bus.req_ready, 1'b1);
    applyStimulus(1, 2'd3, 32'h0000_00BB, 1, '0, 0, '0);

    // Rank change to 3, then reset pulsed while waiting for read data.
    tick();
    checkOutput("rst switch1 cmd", bus.pkg_command, {2'd3, 32'h0});
    checkOutput("rst switch1 valid", bus.pkg_valid, 1'b0);
    applyStimulus(0, 0, 0, 0, '0, 0, '0);
    tick();
    checkOutput("rst switch2 cmd", bus.pkg_command, {2'd3, 32'h0});
    tick();
    checkOutput("rst issue cmd", bus.pkg_command, {2'd3, 32'h0000_00BB});
    checkOutput("rst issue valid", bus.pkg_valid, 1'b1);
    tick();
    tick();
    rstN = 1'b0;
    tick();
    checkOutput("midrst req_ready", bus.req_ready, 1'b0);
    checkOutput("midrst pkg_command", bus.pkg_command, 34'h0);
    checkOutput("midrst pkg_valid", bus.pkg_valid, 1'b0);
    checkOutput("midrst pkg_write_data", bus.pkg_write_data, 128'h0);
    checkOutput("midrst rsp_valid", bus.rsp_valid, 1'b0);
    checkOutput("midrst rsp_data", bus.rsp_data, 128'h0);
    checkOutput("midrst rsp_rank", bus.rsp_rank, 2'd0);
    checkOutput("midrst status_pm", bus.status_pm, 4'd0);
    checkOutput("midrst err_timeout", bus.err_timeout, 1'b0);
    rstN = 1'b1;
    applyStimulus(0, 0, 0, 0, '0, 1, patBeef);
    tick();
    checkOutput("postrst req_ready", bus.req_ready, 1'b1);
    checkOutput("postrst rsp_valid", bus.rsp_valid, 1'b0);
    checkOutput("postrst pkg_command", bus.pkg_command, 34'h0);
    applyStimulus(0, 0, 0, 0, '0, 1, patBeef);
    tick();
    checkOutput("late strobe rsp_valid", bus.rsp_valid, 1'b0);
    checkOutput("late strobe ready", bus.req_ready, 1'b1);
    checkOutput("late strobe err", bus.err_timeout, 1'b0);
    applyStimulus(0, 0, 0, 0, '0, 0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
